stream_scan_ctrl: RTL and testbench

STREAM_SCAN_CTRL -- requirements
Module: stream_scan_ctrl

---
 rtl/stream_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_stream_scan_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : stream_scan_ctrl
// Description : Frame-based bit-serial "1011" pattern scanner.
//               A frame of `len` bytes is accepted over a valid/ready
//               handshake. Each byte is shifted out MSB first into an
//               overlapping "1011" detector. Matches are counted with
//               saturation and a sticky overflow flag. A one-cycle done
//               pulse ends every accepted frame.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-high reset
//   start        in   frame start request (only honoured while busy=0)
//   len[7:0]     in   frame length in words, latched on accepted start
//   in_valid     in   word source has a word on in_data
//   in_data[7:0] in   word to scan, MSB first
//   in_ready     out  controller accepts a word this cycle
//   busy         out  frame in progress
//   done         out  one-cycle end-of-frame pulse
//   match_pulse  out  registered one-cycle pulse per detected "1011"
//   match_count  out  saturating match counter for current/last frame
//   overflow     out  sticky: a match arrived while the counter was full
//   det_state    out  detector state (debug visibility)
// ============================================================================
module stream_scan_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             busy,
  output logic             done,
  output logic             match_pulse,
  output logic [CNT_W-1:0] match_count,
  output logic             overflow,
  output logic [2:0]       det_state
);

  // --------------------------------------------------------------------------
  // Encodings
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Detector encodings are visible on det_state, so they are fixed values.
  localparam logic [2:0] DET_S0    = 3'd0;
  localparam logic [2:0] DET_S1    = 3'd1;
  localparam logic [2:0] DET_S10   = 3'd2;
  localparam logic [2:0] DET_S101  = 3'd3;
  localparam logic [2:0] DET_S1011 = 3'd4;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [7:0]         words_q, words_d;     // words still to scan
  logic [7:0]         shreg_q, shreg_d;     // current word, MSB is next bit
  logic [2:0]         bit_idx_q, bit_idx_d; // bits left in word, minus one
  logic [2:0]         det_q, det_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               pulse_q, pulse_d;

  logic               det_in;
  logic [2:0]         det_nxt;

  // --------------------------------------------------------------------------
  // Detector next-state: longest suffix of the bit history that is also a
  // prefix of "1011". This gives overlapping detection for free
  // (e.g. "1011" followed by "011" reuses the trailing "1").
  // --------------------------------------------------------------------------
  always_comb begin
    det_in  = shreg_q[7];
    det_nxt = DET_S0;
    case (det_q)
      DET_S0:    det_nxt = det_in ? DET_S1    : DET_S0;
      DET_S1:    det_nxt = det_in ? DET_S1    : DET_S10;
      DET_S10:   det_nxt = det_in ? DET_S101  : DET_S0;
      DET_S101:  det_nxt = det_in ? DET_S1011 : DET_S10;
      DET_S1011: det_nxt = det_in ? DET_S1    : DET_S10;
      default:   det_nxt = DET_S0;
    endcase
  end

  // --------------------------------------------------------------------------
  // Controller next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    words_d   = words_q;
    shreg_d   = shreg_q;
    bit_idx_d = bit_idx_q;
    det_d     = det_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    pulse_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Results of the previous frame stay visible until a new start.
        if (start) begin
          words_d = len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          det_d   = DET_S0;
          state_d = (len != 8'd0) ? ST_LOAD : ST_FINISH;
        end
      end

      ST_LOAD: begin
        if (in_valid) begin
          shreg_d   = in_data;
          bit_idx_d = 3'd7;
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        det_d     = det_nxt;
        shreg_d   = {shreg_q[6:0], 1'b0};
        bit_idx_d = bit_idx_q - 3'd1;
        // Count on the same edge the detector enters S1011 so a match on
        // the last bit of a frame is already counted when done is high.
        if (det_nxt == DET_S1011) begin
          pulse_d = 1'b1;
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        if (bit_idx_q == 3'd0) begin
          words_d = words_q - 8'd1;
          state_d = (words_q == 8'd1) ? ST_FINISH : ST_LOAD;
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      words_q   <= 8'd0;
      shreg_q   <= 8'd0;
      bit_idx_q <= 3'd0;
      det_q     <= DET_S0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      words_q   <= words_d;
      shreg_q   <= shreg_d;
      bit_idx_q <= bit_idx_d;
      det_q     <= det_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      pulse_q   <= pulse_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (decoded from registered state only)
  // --------------------------------------------------------------------------
  assign in_ready    = (state_q == ST_LOAD);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FINISH);
  assign match_pulse = pulse_q;
  assign match_count = cnt_q;
  assign overflow    = ovf_q;
  assign det_state   = det_q;

endmodule
`default_nettype wire

// File: tb/tb_stream_scan_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_stream_scan_ctrl
// Description : Self-checking bench for stream_scan_ctrl. Each frame's
//               expected count, overflow, done cycle and match-pulse cycles
//               come from a bit-window reference model and are queued when
//               the frame is driven; a monitor pops and compares them as
//               the DUT produces match_pulse and done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stream_scan_ctrl;

  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [7:0]       len;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             match_pulse;
  logic [CNT_W-1:0] match_count;
  logic             overflow;
  logic [2:0]       det_state;

  always #5 clk = ~clk;

  stream_scan_ctrl #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .done        (done),
    .match_pulse (match_pulse),
    .match_count (match_count),
    .overflow    (overflow),
    .det_state   (det_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    int cnt;
    int ovf;
    int done_cyc;
    int n_pulse;
    int ready_seen;
  } frame_exp_t;

  frame_exp_t exp_q[$];
  int         pulse_q[$];
  logic [7:0] words[$];
  int         stalls[$];

  // Cycle numbering: cyc=1 is the first sample after the start-accepting edge.
  bit arm         = 1'b0;
  int cyc         = 0;
  int pulses_seen = 0;
  int ready_seen  = 0;

  always @(posedge clk) begin
    frame_exp_t e;
    #1;
    if (arm) begin
      cyc         = 1;
      arm         = 1'b0;
      pulses_seen = 0;
      ready_seen  = 0;
    end else begin
      cyc++;
    end
    if (in_ready === 1'b1) ready_seen = 1;
    if (match_pulse === 1'b1) begin
      pulses_seen++;
      if (pulse_q.size() == 0) check("pulse_unexpected", {31'd0, match_pulse}, 32'd0);
      else                     check("pulse_cyc", cyc, pulse_q.pop_front());
    end
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", {31'd0, done}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("done_cyc",    cyc,                 e.done_cyc);
        check("match_count", {24'd0, match_count}, e.cnt);
        check("overflow",    {31'd0, overflow},    e.ovf);
        check("pulse_total", pulses_seen,          e.n_pulse);
        check("ready_seen",  ready_seen,           e.ready_seen);
      end
    end
  end

  // Reference model: sliding 4-bit window over the frame's bit stream.
  task automatic model_frame(input int n);
    frame_exp_t e;
    int         t;
    int         m;
    int         nbits;
    logic [3:0] win;
    logic [7:0] w;
    t = 1; m = 0; nbits = 0; win = 4'd0;
    for (int k = 0; k < n; k++) begin
      t += stalls[k];
      w = words[k];
      for (int j = 0; j < 8; j++) begin
        win = {win[2:0], w[3'(7 - j)]};
        nbits++;
        if (nbits >= 4 && win == 4'b1011) begin
          m++;
          pulse_q.push_back(t + 2 + j);
        end
      end
      t += 9;
    end
    e.done_cyc   = t;
    e.cnt        = (m > CNT_MAX) ? CNT_MAX : m;
    e.ovf        = (m > CNT_MAX) ? 1 : 0;
    e.n_pulse    = m;
    e.ready_seen = (n != 0) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Called at posedge+2 with the DUT idle. Optionally pokes start while busy.
  task automatic run_frame(input int n, input bit poke);
    int b;
    model_frame(n);
    len   = n[7:0];
    start = 1'b1;
    arm   = 1'b1;
    @(posedge clk); #2;
    if (poke) begin
      start = 1'b1;
      len   = 8'd5;
    end else begin
      start = 1'b0;
    end
    for (int k = 0; k < n; k++) begin
      in_valid = (stalls[k] == 0);
      in_data  = words[k];
      b = 0;
      while (in_ready !== 1'b1 && b < 20) begin
        @(posedge clk); #2;
        b++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      if (stalls[k] > 0) begin
        repeat (stalls[k]) begin @(posedge clk); #2; end
        in_valid = 1'b1;
      end
      @(posedge clk); #2;
      start = 1'b0;
    end
    b = 0;
    while (busy !== 1'b0 && b < 3000) begin
      @(posedge clk); #2;
      b++;
      start = 1'b0;
    end
    check("idle_wait", {31'd0, busy}, 32'd0);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; len = 8'd0; in_valid = 1'b0; in_data = 8'd0;
    #3;
    check("reset_outs", {in_ready, busy, done, match_pulse, overflow, det_state},
          8'd0);
    check("reset_count", {24'd0, match_count}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Single word, one match on the last bit, in_valid held high.
    words = '{8'h0B}; stalls = '{0};
    run_frame(1, 1'b0);

    // Overlap through S1011->S10; start poked while busy must be ignored.
    words = '{8'hB6}; stalls = '{0};
    run_frame(1, 1'b1);

    // Match straddling a word boundary with a 3-cycle source stall.
    words = '{8'h01, 8'h60}; stalls = '{0, 3};
    run_frame(2, 1'b0);

    // Saturation: 260 matches into an 8-bit counter.
    words.delete(); stalls.delete();
    for (int i = 0; i < 130; i++) begin
      words.push_back(8'hBB);
      stalls.push_back(0);
    end
    run_frame(130, 1'b0);
    repeat (3) begin @(posedge clk); #2; end
    check("hold_count", {24'd0, match_count}, CNT_MAX);
    check("hold_ovf",   {31'd0, overflow},    32'd1);

    // Zero-length frame goes straight to FINISH and clears old results.
    words.delete(); stalls.delete();
    run_frame(0, 1'b0);

    // Reset during SHIFT of word 2 of a 3-word frame.
    len = 8'd3; start = 1'b1; in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #2;           // LOAD
    start = 1'b0;
    @(posedge clk); #2;           // word 1 shifting
    repeat (8) begin @(posedge clk); #2; end
    @(posedge clk); #2;           // word 2 loaded
    repeat (2) begin @(posedge clk); #2; end
    check("pre_rst_busy", {30'd0, busy, in_ready}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_outs", {in_ready, busy, done, match_pulse, overflow, det_state},
          8'd0);
    check("midrst_count", {24'd0, match_count}, 32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    words = '{8'h0B}; stalls = '{0};
    run_frame(1, 1'b0);

    repeat (3) begin @(posedge clk); #2; end
    check("exp_q_empty",   exp_q.size(),   32'd0);
    check("pulse_q_empty", pulse_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
